seq_detect_ctrl: RTL and testbench
==================================

Name: seq_detect_ctrl

Overview:
Sequencing controller for the serial pattern-detection path. It accepts parallel words over a valid/ready handshake and serializes them MSB-first into a bit stream. It runs a programmable pattern matcher on that stream, up to PAT_MAX bits, with overlapping matches counted. It counts matches, stops on a match limit or at the end of the burst, and reports busy/done/err to the host.

Parameters:
WORD_W, 8, input word width (bits serialized per word)
PAT_MAX, 8, maximum pattern length in bits
CNT_W, 16, width of match counter and match limit

Ports:
clk  input  1  single clock; all state changes on posedge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  pulse; begins a run when idle
pattern  input  PAT_MAX  pattern bits; pattern[pat_len-1] is matched first (oldest bit)
pat_len  input  4  pattern length, legal range 1..PAT_MAX
match_limit  input  CNT_W  stop after this many matches; 0 = unlimited
in_valid  input  1  input word valid
in_data  input  WORD_W  input word
in_last  input  1  marks final word of the burst; qualified by in_valid
in_ready  output  1  controller can accept a word
bit_out  output  1  current serialized bit
bit_valid  output  1  bit_out is valid this cycle
match  output  1  one-cycle pulse per detected match
match_count  output  CNT_W  matches in the current run
busy  output  1  run in progress
done  output  1  one-cycle pulse at end of run
err  output  1  config error; held until next accepted start

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs are 0: in_ready, bit_out, bit_valid, match, match_count, busy, done, err. History, bit counter and latched config are cleared.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - On start=1, latch pattern, pat_len and match_limit; clear history, bits-seen counter and match_count; clear err.
  - If pat_len==0 or pat_len>PAT_MAX: set err=1 and go to DONE. Otherwise go to LOAD.
- LOAD:
  - in_ready=1 and busy=1.
  - A word is accepted when in_valid=1 and in_ready=1. On acceptance, capture in_data and in_last, then go to SHIFT.
- SHIFT:
  - Runs WORD_W cycles with bit_valid=1. bit_out = captured word MSB first, so bit WORD_W-1 appears in the first cycle.
  - Each bit shifts into a PAT_MAX-bit history register. The bits-seen counter saturates at PAT_MAX.
  - After the final bit: go to DONE if the captured in_last=1, otherwise go to LOAD.
- Latency: a word accepted in cycle t drives bit_out in cycles t+1..t+WORD_W. The next in_ready is asserted at t+WORD_W+1, giving WORD_W+1 cycles per word.
- Match:
  - A match occurs when the low pat_len bits of history, including the current bit, equal pattern[pat_len-1:0] and bits-seen ≥ pat_len.
  - match pulses in the cycle after the matching bit. match_count increments in the same cycle and saturates at 2^CNT_W-1.
  - History carries across word boundaries within a run.
- Limit: if match_limit≠0 and the increment makes match_count==match_limit, the next state is DONE. The match pulse and the DONE entry occur in the same cycle. Remaining bits of the word are discarded, and the burst remainder is not drained.
- DONE: done=1 and busy=0 for one cycle, then go to IDLE. match_count holds its value until the next start.
- busy=1 in LOAD and SHIFT, and for the trailing match-pulse cycle.
- start is ignored outside IDLE. A config change during a run has no effect.
- Reset mid-run aborts immediately. Any pending match pulse is lost.

Optional Feature:
NONOVERLAP_EN
- Defined: on a match, the bits-seen counter clears to 0, so the next match requires pat_len fresh bits (non-overlapping detection).
- Undefined: overlapping matches are all counted.

Test Plan:
- Overlapping ones: pattern=8'b0000_0111, pat_len=3, limit=0, one word 8'hFF with in_last=1. Expect 6 match pulses, one after each of bits 3..8. match_count=6, then done. With NONOVERLAP_EN defined: 2 matches, count=2.
- Limit stop: same run with limit=2. Expect done in the cycle after the 2nd match, bit_valid deasserted early, match_count=2, and in_ready never reasserted.
- Word boundary: pattern=3'b101, pat_len=3, words 8'h01 then 8'h40 (last). Expect exactly 1 match, after stream bit 10, giving count=1. Also check a 1-cycle gap with in_ready=1 between the two words.
- Bad config: pat_len=0 with start. Expect err=1, done the next cycle, in_ready never asserted, count=0. A following legal start clears err.
- Back-pressure and busy: hold in_valid=0 for 5 cycles in LOAD. Expect in_ready held at 1, bit_valid=0 and no state advance. A start pulse mid-run has no effect.
- Async reset: drive reset=0 mid-SHIFT without a clock edge. Expect all outputs 0 immediately. After release, the block is idle and accepts a new start.

Source files
------------

// File: rtl/seq_detect_ctrl_if.sv
// Word-input handshake bundle for seq_detect_ctrl: the host drives the word side
// (master), the controller answers with in_ready (slave).
interface seq_detect_ctrl_if #(
  parameter int WORD_W = 8
);
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;

  modport master (output in_valid, in_data, in_last, input  in_ready);
  modport slave  (input  in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/seq_detect_ctrl.sv
// Serializes handshaken words MSB-first and counts programmable pattern matches.
// Optional build macro NONOVERLAP_EN selects non-overlapping match detection.
module seq_detect_ctrl #(
  parameter int WORD_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PAT_MAX-1:0] pattern,
  input  logic [3:0]         pat_len,
  input  logic [CNT_W-1:0]   match_limit,
  seq_detect_ctrl_if.slave   up,
  output logic               bit_out,
  output logic               bit_valid,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int SEEN_W = $clog2(PAT_MAX + 1);
  localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [PAT_MAX-1:0]  pat_q, hist_q, hist_d, mask;
  logic [3:0]          len_q;
  logic [CNT_W-1:0]    lim_q, cnt_d;
  logic [SEEN_W-1:0]   seen_q, seen_d;
  logic [WORD_W-1:0]   word_q;
  logic                last_q;
  logic [IDX_W-1:0]    idx_q;
  logic                match_q, err_q, hit, bad_cfg, bit_last;

  assign bad_cfg  = (pat_len == 4'd0) || (int'(pat_len) > PAT_MAX);
  assign bit_last = (idx_q == IDX_W'(WORD_W - 1));

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    cnt_d   = match_count;
    mask    = '0;
    hist_d  = {hist_q[PAT_MAX-2:0], word_q[WORD_W-1]};
    seen_d  = (seen_q == SEEN_W'(PAT_MAX)) ? seen_q : seen_q + 1'b1;
    for (int i = 0; i < PAT_MAX; i++) mask[i] = (i < int'(len_q));

    case (state_q)
      IDLE:  if (start) state_d = bad_cfg ? DONE : LOAD;
      LOAD:  if (up.in_valid) state_d = SHIFT;
      SHIFT: begin
        hit = (((hist_d ^ pat_q) & mask) == '0) && (int'(seen_d) >= int'(len_q));
        if (hit && (match_count != '1)) cnt_d = match_count + 1'b1;
        // Reaching the limit ends the run at once; the rest of the word is dropped.
        if ((hit && (lim_q != '0) && (cnt_d == lim_q)) || (bit_last && last_q))
          state_d = DONE;
        else if (bit_last)
          state_d = LOAD;
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the history, word and config registers are reset too, so a run never sees stale bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      lim_q       <= '0;
      hist_q      <= '0;
      seen_q      <= '0;
      word_q      <= '0;
      last_q      <= 1'b0;
      idx_q       <= '0;
      match_q     <= 1'b0;
      match_count <= '0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in step with the edge.
      state_q <= state_d;
      match_q <= hit;
      case (state_q)
        IDLE: if (start) begin
          pat_q       <= pattern;
          len_q       <= pat_len;
          lim_q       <= match_limit;
          hist_q      <= '0;
          seen_q      <= '0;
          match_count <= '0;
          err_q       <= bad_cfg;
        end
        LOAD: if (up.in_valid) begin
          word_q <= up.in_data;
          last_q <= up.in_last;
          idx_q  <= '0;
        end
        SHIFT: begin
          word_q      <= word_q << 1;
          idx_q       <= idx_q + 1'b1;
          hist_q      <= hist_d;
          match_count <= cnt_d;
`ifdef NONOVERLAP_EN
          seen_q      <= hit ? '0 : seen_d;
`else
          seen_q      <= seen_d;
`endif
        end
        default: ;
      endcase
    end
  end

  assign up.in_ready = (state_q == LOAD);
  assign bit_valid   = (state_q == SHIFT);
  assign bit_out     = (state_q == SHIFT) && word_q[WORD_W-1];
  assign match       = match_q;
  // The pulse for a match on the final bit lands after SHIFT; busy covers it.
  assign busy        = (state_q == LOAD) || (state_q == SHIFT) || match_q;
  assign done        = (state_q == DONE);
  assign err         = err_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: a stream-level reference model checked
// every cycle, plus directed runs with hand-computed results.
module tb_seq_detect_ctrl;
  localparam int W  = 8;
  localparam int PM = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [PM-1:0] pattern = '0;
  logic [3:0]    pat_len = '0;
  logic [CW-1:0] match_limit = '0;
  logic          bit_out, bit_valid, match, busy, done, err;
  logic [CW-1:0] match_count;

  seq_detect_ctrl_if #(.WORD_W(W)) bus ();

  seq_detect_ctrl #(.WORD_W(W), .PAT_MAX(PM), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .pat_len(pat_len),
    .match_limit(match_limit), .up(bus), .bit_out(bit_out), .bit_valid(bit_valid),
    .match(match), .match_count(match_count), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of bits still to be emitted and an integer history.
  bit q[$];
  int m_hist, m_seen, m_cnt, m_len, m_pat, m_lim;
  bit m_active, m_last, m_done, m_match, m_err, m_was_done, m_hit;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_hist = 0; m_seen = 0; m_cnt = 0; m_len = 0; m_pat = 0; m_lim = 0;
      m_active = 0; m_last = 0; m_done = 0; m_match = 0; m_err = 0;
    end else begin
      m_was_done = m_done;
      m_done = 0;
      m_match = 0;
      if (m_was_done) begin
        // done lasts one cycle, then the block is idle again
      end else if (!m_active) begin
        if (start) begin
          m_pat = int'(pattern); m_len = int'(pat_len); m_lim = int'(match_limit);
          m_cnt = 0; m_hist = 0; m_seen = 0;
          m_err = (m_len < 1) || (m_len > PM);
          if (m_err) m_done = 1; else m_active = 1;
        end
      end else if (q.size() == 0) begin
        if (bus.in_valid) begin
          for (int i = W - 1; i >= 0; i--) q.push_back(bus.in_data[i]);
          m_last = bus.in_last;
        end
      end else begin
        m_hist = ((m_hist << 1) | int'(q.pop_front())) & ((1 << PM) - 1);
        if (m_seen < PM) m_seen++;
        m_hit = (m_seen >= m_len) &&
                ((m_hist & ((1 << m_len) - 1)) == (m_pat & ((1 << m_len) - 1)));
        if (m_hit) begin
          m_match = 1;
          if (m_cnt < (1 << CW) - 1) m_cnt++;
`ifdef NONOVERLAP_EN
          m_seen = 0;
`endif
          if (m_lim != 0 && m_cnt == m_lim) begin
            q.delete(); m_active = 0; m_done = 1;
          end
        end
        if (m_active && q.size() == 0 && m_last) begin
          m_active = 0; m_done = 1;
        end
      end
    end
  end

  int  tests = 0;
  int  fails = 0;
  int  pulses = 0;
  bit  chk_en = 0;
  time acc_t = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    check("in_ready",    32'(bus.in_ready),  32'(m_active && q.size() == 0));
    check("bit_valid",   32'(bit_valid),     32'(m_active && q.size() > 0));
    check("bit_out",     32'(bit_out),       32'((m_active && q.size() > 0) ? q[0] : 1'b0));
    check("match",       32'(match),         32'(m_match));
    check("match_count", 32'(match_count),   32'(m_cnt));
    check("busy",        32'(busy),          32'(m_active || m_match));
    check("done",        32'(done),          32'(m_done));
    check("err",         32'(err),           32'(m_err));
  endtask

  task automatic do_start(input logic [PM-1:0] p, input logic [3:0] l, input logic [CW-1:0] lim);
    @(negedge clk);
    pattern = p; pat_len = l; match_limit = lim; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d, input bit last);
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = last;
        @(posedge clk);
        acc_t = $time;
        ok = 1;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
      end
    end
    check("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check({nm, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  int  base, exp_n;
  bit  saw;
  time t1;

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (reset && match) pulses++;
        if (chk_en) compare_cycle();
      end
    join_none

    // Reset state
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_bit_valid", 32'(bit_valid), 32'd0);
    check("rst_bit_out", 32'(bit_out), 32'd0);
    check("rst_match", 32'(match), 32'd0);
    check("rst_count", 32'(match_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    chk_en = 1;

    // Overlapping ones
`ifdef NONOVERLAP_EN
    exp_n = 2;
`else
    exp_n = 6;
`endif
    base = pulses;
    do_start(8'b0000_0111, 4'd3, 16'd0);
    send(8'hFF, 1'b1);
    wait_done("overlap");
    @(negedge clk);
    check("overlap_pulses", 32'(pulses - base), 32'(exp_n));
    check("overlap_count", 32'(match_count), 32'(exp_n));

    // Limit stop
    base = pulses;
    do_start(8'b0000_0111, 4'd3, 16'd2);
    send(8'hFF, 1'b1);
    wait_done("limit");
    check("limit_count", 32'(match_count), 32'd2);
    saw = 0;
    repeat (12) begin @(negedge clk); saw |= bus.in_ready; end
    check("limit_pulses", 32'(pulses - base), 32'd2);
    check("limit_no_ready", 32'(saw), 32'd0);

    // Bad config
    do_start(8'h05, 4'd0, 16'd0);
    check("bad_err", 32'(err), 32'd1);
    check("bad_done", 32'(done), 32'd1);
    check("bad_count", 32'(match_count), 32'd0);
    repeat (3) @(negedge clk);
    check("bad_err_held", 32'(err), 32'd1);

    // Word boundary; the legal start also clears err
    base = pulses;
    do_start(8'b0000_0101, 4'd3, 16'd0);
    check("err_cleared", 32'(err), 32'd0);
    send(8'h01, 1'b0);
    t1 = acc_t;
    send(8'h40, 1'b1);
    check("word_period", 32'((acc_t - t1) / 10), 32'(W + 1));
    wait_done("boundary");
    @(negedge clk);
    check("boundary_pulses", 32'(pulses - base), 32'd1);
    check("boundary_count", 32'(match_count), 32'd1);

    // Back-pressure with a stray start carrying a different config
`ifdef NONOVERLAP_EN
    exp_n = 1;
`else
    exp_n = 2;
`endif
    base = pulses;
    do_start(8'b0000_0111, 4'd3, 16'd0);
    repeat (5) @(negedge clk);
    check("bp_ready_held", 32'(bus.in_ready), 32'd1);
    check("bp_busy", 32'(busy), 32'd1);
    pattern = 8'h00; pat_len = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("bp_ready_after_start", 32'(bus.in_ready), 32'd1);
    send(8'h0F, 1'b1);
    wait_done("bp");
    @(negedge clk);
    check("bp_pulses", 32'(pulses - base), 32'(exp_n));

    // Async reset mid-SHIFT
    do_start(8'b0000_0011, 4'd2, 16'd0);
    send(8'hAA, 1'b1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_bit_valid", 32'(bit_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd0);
    check("arst_count", 32'(match_count), 32'd0);
    check("arst_bit_out", 32'(bit_out), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'(busy), 32'd0);

    // Fresh run after reset
`ifdef NONOVERLAP_EN
    exp_n = 2;
`else
    exp_n = 6;
`endif
    do_start(8'b0000_0111, 4'd3, 16'd0);
    send(8'hFF, 1'b1);
    wait_done("post_rst");
    check("post_rst_count", 32'(match_count), 32'(exp_n));
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
